// File: rtl/t07_spi_reg_arbiter.sv
// t07_spi_reg_arbiter
// Arbitrates writes into a shared external register file between a buffered
// SPI word stream and a blocking CPU write port. SPI words wait in a small
// FIFO. The CPU port has no buffering. When both sources are waiting, the
// arbiter grants them in round-robin order. Writes are issued one at a time
// with a registered strobe, address and data. Each write is held until the
// register file signals ready.

module t07_spi_reg_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          spi_valid,
  input  logic [5:0]                    spi_addr,
  input  logic [31:0]                   spi_data,
  input  logic                          cpu_req,
  input  logic [5:0]                    cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic                          cpu_done,
  output logic                          reg_we,
  output logic [5:0]                    reg_addr,
  output logic [31:0]                   reg_wdata,
  input  logic                          reg_ready,
  output logic                          spi_drop,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  // last_grant encoding: records which source was served most recently
  localparam logic GRANT_SPI = 1'b1;
  localparam logic GRANT_CPU = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPI_WR = 2'd1,
    CPU_WR = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  // FIFO storage: {addr[5:0], data[31:0]} per entry
  logic [37:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;

  logic          last_grant_r;
  logic          cpu_seen_r;
  logic          reg_we_r;
  logic [5:0]    reg_addr_r;
  logic [31:0]   reg_wdata_r;
  logic          spi_drop_r;
  logic [7:0]    drop_count_r;

  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic          spi_pend_s;
  logic          cpu_pend_s;
  logic          cpu_done_s;
  logic [37:0]   head_s;

  assign fifo_full_s  = (level_r == LEVEL_FULL);
  assign fifo_empty_s = (level_r == LEVEL_ZERO);
  assign head_s       = fifo_mem[rd_ptr_r];

  // The head entry stays in the FIFO for the whole SPI write.
  // It is popped only in the cycle the register file accepts the write.
  assign pop_s      = (state_r == SPI_WR) && reg_ready;
  assign cpu_done_s = (state_r == CPU_WR) && reg_ready;

  // A full FIFO still takes a new word if the head leaves in the same cycle.
  assign push_s = spi_valid && (!fifo_full_s || pop_s);
  assign drop_s = spi_valid && fifo_full_s && !pop_s;

  // The CPU request is qualified one cycle after it is seen. This gives CPU
  // and SPI the same request-to-strobe latency, so arrivals in the same
  // cycle tie. It also masks the stale cpu_req level in the cycle that
  // follows cpu_done.
  assign spi_pend_s = !fifo_empty_s;
  assign cpu_pend_s = cpu_req && cpu_seen_r;

  assign cpu_done   = cpu_done_s;
  assign reg_we     = reg_we_r;
  assign reg_addr   = reg_addr_r;
  assign reg_wdata  = reg_wdata_r;
  assign spi_drop   = spi_drop_r;
  assign drop_count = drop_count_r;
  assign fifo_level = level_r;

  // FIFO data array (no reset needed, validity is tracked by level_r)
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_r] <= {spi_addr, spi_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Drop pulse (one cycle after the discarded word) and saturating drop count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      spi_drop_r   <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      spi_drop_r <= drop_s;
      if (drop_s && (drop_count_r != 8'hFF)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end
    end
  end

  // CPU request qualifier; cleared by cpu_done so a finished request is not re-granted
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cpu_seen_r <= 1'b0;
    end else begin
      cpu_seen_r <= cpu_req && !cpu_done_s;
    end
  end

  // Round-robin memory: starts at CPU so SPI wins the first tie
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_grant_r <= GRANT_CPU;
    end else if (pop_s) begin
      last_grant_r <= GRANT_SPI;
    end else if (cpu_done_s) begin
      last_grant_r <= GRANT_CPU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: grant from IDLE, hold a write state until reg_ready
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (spi_pend_s && cpu_pend_s) begin
          if (last_grant_r == GRANT_CPU) begin
            state_s = SPI_WR;
          end else begin
            state_s = CPU_WR;
          end
        end else if (spi_pend_s) begin
          state_s = SPI_WR;
        end else if (cpu_pend_s) begin
          state_s = CPU_WR;
        end else begin
          state_s = IDLE;
        end
      end
      SPI_WR: begin
        if (reg_ready) begin
          state_s = IDLE;
        end else begin
          state_s = SPI_WR;
        end
      end
      CPU_WR: begin
        if (reg_ready) begin
          state_s = IDLE;
        end else begin
          state_s = CPU_WR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Registered write port: load address/data on entry to a write state, hold until accepted
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reg_we_r    <= 1'b0;
      reg_addr_r  <= 6'd0;
      reg_wdata_r <= 32'd0;
    end else begin
      reg_we_r <= (state_s != IDLE);
      if ((state_r == IDLE) && (state_s == SPI_WR)) begin
        reg_addr_r  <= head_s[37:32];
        reg_wdata_r <= head_s[31:0];
      end else if ((state_r == IDLE) && (state_s == CPU_WR)) begin
        reg_addr_r  <= cpu_addr;
        reg_wdata_r <= cpu_wdata;
      end else begin
        reg_addr_r  <= reg_addr_r;
        reg_wdata_r <= reg_wdata_r;
      end
    end
  end

endmodule

// File: tb/tb_t07_spi_reg_arbiter.sv
// Scoreboard bench for t07_spi_reg_arbiter: expected register writes are
// queued as stimulus is driven and checked as each write is accepted.

module tb_t07_spi_reg_arbiter;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        spi_valid;
  logic [5:0]  spi_addr;
  logic [31:0] spi_data;
  logic        cpu_req;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_done;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ready;
  logic        spi_drop;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_level;

  t07_spi_reg_arbiter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .spi_valid  (spi_valid),
    .spi_addr   (spi_addr),
    .spi_data   (spi_data),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_done   (cpu_done),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_ready  (reg_ready),
    .spi_drop   (spi_drop),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        is_cpu;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  n_writes     = 0;
  int  n_drops      = 0;
  int  n_done       = 0;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (nrst) begin
      if (spi_drop) n_drops++;
      if (cpu_done) n_done++;
      if (reg_we && reg_ready) begin
        n_writes++;
        check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("wr_addr", 32'(reg_addr), 32'(mon_e.addr));
          check_eq("wr_data", reg_wdata, mon_e.data);
          check_eq("wr_cpu_done", 32'(cpu_done), 32'(mon_e.is_cpu));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_writes = 0;
    n_drops  = 0;
    n_done   = 0;
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    spi_valid = 1'b0;
    cpu_req   = 1'b0;
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    exp_q.delete();
    clear_counts();
  endtask

  task automatic spi_send(input logic [5:0] a, input logic [31:0] d);
    spi_valid = 1'b1;
    spi_addr  = a;
    spi_data  = d;
    tick();
    spi_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
    bit seen;
    seen      = 1'b0;
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("cpu_done_seen", 32'(seen), 32'd1);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    nrst      = 1'b0;
    spi_valid = 1'b0;
    spi_addr  = 6'd0;
    spi_data  = 32'd0;
    cpu_req   = 1'b0;
    cpu_addr  = 6'd0;
    cpu_wdata = 32'd0;
    reg_ready = 1'b0;
    #3;
    // reset state
    check_eq("rst_reg_we", 32'(reg_we), 32'd0);
    check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_reg_wdata", reg_wdata, 32'd0);
    check_eq("rst_cpu_done", 32'(cpu_done), 32'd0);
    check_eq("rst_spi_drop", 32'(spi_drop), 32'd0);
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);
    check_eq("rst_fifo_level", 32'(fifo_level), 32'd0);

    // single SPI word: strobe two cycles after spi_valid
    do_reset();
    reg_ready = 1'b1;
    exp_q.push_back('{addr: 6'h05, data: 32'hDEADBEEF, is_cpu: 1'b0});
    spi_send(6'h05, 32'hDEADBEEF);
    check_eq("lat_n1_we", 32'(reg_we), 32'd0);
    check_eq("lat_n1_level", 32'(fifo_level), 32'd1);
    tick();
    check_eq("lat_n2_we", 32'(reg_we), 32'd1);
    check_eq("lat_n2_addr", 32'(reg_addr), 32'h05);
    check_eq("lat_n2_data", reg_wdata, 32'hDEADBEEF);
    tick();
    check_eq("lat_n3_we", 32'(reg_we), 32'd0);
    check_eq("lat_n3_level", 32'(fifo_level), 32'd0);
    wait_drain("single_drain");
    check_eq("single_writes", 32'(n_writes), 32'd1);

    // SPI and CPU arriving together after reset: SPI first
    do_reset();
    reg_ready = 1'b1;
    exp_q.push_back('{addr: 6'h21, data: 32'hA5A5A5A5, is_cpu: 1'b0});
    exp_q.push_back('{addr: 6'h10, data: 32'h12345678, is_cpu: 1'b1});
    fork
      spi_send(6'h21, 32'hA5A5A5A5);
      cpu_write(6'h10, 32'h12345678);
    join
    wait_drain("tie_drain");
    check_eq("tie_done_count", 32'(n_done), 32'd1);

    // CPU write held by reg_ready low for five cycles
    clear_counts();
    reg_ready = 1'b0;
    exp_q.push_back('{addr: 6'h2A, data: 32'hCAFEF00D, is_cpu: 1'b1});
    cpu_req   = 1'b1;
    cpu_addr  = 6'h2A;
    cpu_wdata = 32'hCAFEF00D;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_we", 32'(reg_we), 32'd1);
      check_eq("hold_addr", 32'(reg_addr), 32'h2A);
      check_eq("hold_data", reg_wdata, 32'hCAFEF00D);
      check_eq("hold_no_done", 32'(cpu_done), 32'd0);
      tick();
    end
    reg_ready = 1'b1;
    #1;
    check_eq("hold_done", 32'(cpu_done), 32'd1);
    tick();
    cpu_req = 1'b0;
    wait_drain("hold_drain");
    check_eq("hold_done_count", 32'(n_done), 32'd1);

    // overflow: six words into a depth-4 FIFO with the register file stalled
    do_reset();
    reg_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back('{addr: 6'(8 + i), data: 32'h1000_0000 + 32'(i), is_cpu: 1'b0});
      spi_send(6'(8 + i), 32'h1000_0000 + 32'(i));
    end
    tick();
    check_eq("ovf_drops", 32'(n_drops), 32'd2);
    check_eq("ovf_drop_count", 32'(drop_count), 32'd2);
    check_eq("ovf_level", 32'(fifo_level), 32'd4);
    check_eq("ovf_head_addr", 32'(reg_addr), 32'h08);
    // full FIFO with a same-cycle pop still accepts the new word
    exp_q.push_back('{addr: 6'h3F, data: 32'h7777_0007, is_cpu: 1'b0});
    reg_ready = 1'b1;
    spi_send(6'h3F, 32'h7777_0007);
    check_eq("pushpop_level", 32'(fifo_level), 32'd4);
    tick();
    check_eq("pushpop_drop_count", 32'(drop_count), 32'd2);
    wait_drain("ovf_drain");
    check_eq("ovf_level_empty", 32'(fifo_level), 32'd0);
    check_eq("ovf_writes", 32'(n_writes), 32'd5);

    // continuous contention: grants alternate SPI, CPU, SPI, CPU
    do_reset();
    reg_ready = 1'b1;
    exp_q.push_back('{addr: 6'h01, data: 32'hAAAA0001, is_cpu: 1'b0});
    exp_q.push_back('{addr: 6'h31, data: 32'hCCCC0001, is_cpu: 1'b1});
    exp_q.push_back('{addr: 6'h02, data: 32'hAAAA0002, is_cpu: 1'b0});
    exp_q.push_back('{addr: 6'h32, data: 32'hCCCC0002, is_cpu: 1'b1});
    exp_q.push_back('{addr: 6'h03, data: 32'hAAAA0003, is_cpu: 1'b0});
    exp_q.push_back('{addr: 6'h33, data: 32'hCCCC0003, is_cpu: 1'b1});
    fork
      begin
        spi_send(6'h01, 32'hAAAA0001);
        spi_send(6'h02, 32'hAAAA0002);
        spi_send(6'h03, 32'hAAAA0003);
      end
      begin
        cpu_write(6'h31, 32'hCCCC0001);
        cpu_write(6'h32, 32'hCCCC0002);
        cpu_write(6'h33, 32'hCCCC0003);
      end
    join
    wait_drain("rr_drain");
    check_eq("rr_done_count", 32'(n_done), 32'd3);

    // drop counter saturates at 255, then reset clears it
    do_reset();
    reg_ready = 1'b0;
    for (int i = 0; i < 4 + 260; i++) begin
      spi_send(6'(i), 32'(i));
    end
    tick();
    check_eq("sat_drop_count", 32'(drop_count), 32'd255);
    check_eq("sat_drops", 32'(n_drops), 32'd260);
    nrst = 1'b0;
    #1;
    check_eq("sat_rst_count", 32'(drop_count), 32'd0);

    // reset in the middle of an SPI write with three words buffered
    do_reset();
    reg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_send(6'(20 + i), 32'h5000_0000 + 32'(i));
    end
    tick();
    check_eq("mid_pre_level", 32'(fifo_level), 32'd3);
    check_eq("mid_pre_we", 32'(reg_we), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(reg_we), 32'd0);
    check_eq("mid_rst_addr", 32'(reg_addr), 32'd0);
    check_eq("mid_rst_data", reg_wdata, 32'd0);
    check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
    check_eq("mid_rst_done", 32'(cpu_done), 32'd0);
    reg_ready = 1'b1;
    tick();
    nrst = 1'b1;
    clear_counts();
    repeat (10) tick();
    check_eq("mid_no_writes", 32'(n_writes), 32'd0);
    check_eq("mid_no_done", 32'(n_done), 32'd0);
    check_eq("mid_level_after", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
